sram_arbiter: RTL

- Two-requester round-robin arbiter and sequencer in front of the 64x8 single-port synchronous static RAM.
- Accepts read/write commands from requesters A and B, serialises them onto the RAM's ce/rw/addr/bidirectional-data interface, and returns read data with a one-cycle valid pulse.
- Owns the bus-direction discipline: drives the RAM data bus only during write cycles and tristates it otherwise.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/sram_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM arbiter/sequencer.
// Holds the sequencer state encoding, RAM direction codes, requester indices
// and the default RAM geometry (64 x 8).
package sram_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 6;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req_a, req_b : request inputs
//   en           : arbitration allowed this cycle (no grant when low)
//   last         : index of the most recent winner (pointer held by parent)
//   gnt          : one-hot grant, bit 0 = A, bit 1 = B
//   win          : index of the winner (only meaningful when |gnt)
module rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic       req_a,
    input  logic       req_b,
    input  logic       en,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       win
);

    // On a conflict the requester that did not win last time goes first.
    always_comb begin
        gnt = 2'b00;
        win = REQ_A;
        if (req_a && req_b) begin
            win = (last == REQ_A) ? REQ_B : REQ_A;
        end else if (req_b) begin
            win = REQ_B;
        end
        if (en) begin
            gnt[0] = req_a && (win == REQ_A);
            gnt[1] = req_b && (win == REQ_B);
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port synchronous SRAM.
// Ports:
//   i_clk, i_reset                    : clock, async active-high reset
//   i_x_req/we/addr/wdata (x = a, b)  : requester command, held until granted
//   o_x_gnt                           : combinational grant (IDLE cycle only)
//   o_x_rvalid, o_x_rdata             : registered read return, 1-cycle pulse
//   o_ram_ce, o_ram_rw, o_ram_addr    : registered RAM control
//   io_ram_data                       : RAM data bus, driven only in write cycles
module sram_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_a_req,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic              o_a_gnt,
    output logic              o_a_rvalid,
    output logic [DATA_W-1:0] o_a_rdata,

    input  logic              i_b_req,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    output logic              o_b_gnt,
    output logic              o_b_rvalid,
    output logic [DATA_W-1:0] o_b_rdata,

    output logic              o_ram_ce,
    output logic              o_ram_rw,
    output logic [ADDR_W-1:0] o_ram_addr,
    inout  wire  [DATA_W-1:0] io_ram_data
);

    state_t            state_q, state_nxt;
    logic              ce_nxt, rw_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic              last_q, last_nxt;
    logic              owner_q, owner_nxt;
    logic              a_rvalid_nxt, b_rvalid_nxt;
    logic [DATA_W-1:0] a_rdata_nxt, b_rdata_nxt;

    logic [1:0]        arb_gnt;
    logic              arb_win;

    // Arbitration is only enabled in IDLE, so grants never appear mid-operation.
    rr_arb2 u_arb (
        .req_a (i_a_req),
        .req_b (i_b_req),
        .en    (state_q == IDLE),
        .last  (last_q),
        .gnt   (arb_gnt),
        .win   (arb_win)
    );

    assign o_a_gnt = arb_gnt[0];
    assign o_b_gnt = arb_gnt[1];

    // Output enable follows the registered direction only, so the controller
    // and the RAM can never drive the bus in the same cycle.
    assign io_ram_data = (o_ram_rw == RW_WRITE) ? wdata_q : {DATA_W{1'bz}};

    // Next-state and next-register values.
    always_comb begin
        state_nxt    = state_q;
        ce_nxt       = 1'b0;
        rw_nxt       = RW_READ;
        addr_nxt     = o_ram_addr;
        wdata_nxt    = wdata_q;
        last_nxt     = last_q;
        owner_nxt    = owner_q;
        a_rvalid_nxt = 1'b0;
        b_rvalid_nxt = 1'b0;
        a_rdata_nxt  = o_a_rdata;
        b_rdata_nxt  = o_b_rdata;

        unique case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    ce_nxt    = 1'b1;
                    last_nxt  = arb_win;
                    owner_nxt = arb_win;
                    if (arb_win == REQ_A) begin
                        rw_nxt    = i_a_we ? RW_WRITE : RW_READ;
                        addr_nxt  = i_a_addr;
                        wdata_nxt = i_a_wdata;
                        state_nxt = i_a_we ? WR : RD_ADDR;
                    end else begin
                        rw_nxt    = i_b_we ? RW_WRITE : RW_READ;
                        addr_nxt  = i_b_addr;
                        wdata_nxt = i_b_wdata;
                        state_nxt = i_b_we ? WR : RD_ADDR;
                    end
                end
            end
            WR: begin
                state_nxt = IDLE;
            end
            RD_ADDR: begin
                state_nxt = RD_DATA;
            end
            RD_DATA: begin
                // RAM is driving the bus this cycle; capture for the owner.
                if (owner_q == REQ_A) begin
                    a_rdata_nxt  = io_ram_data;
                    a_rvalid_nxt = 1'b1;
                end else begin
                    b_rdata_nxt  = io_ram_data;
                    b_rvalid_nxt = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            o_ram_ce   <= 1'b0;
            o_ram_rw   <= RW_READ;
            o_ram_addr <= '0;
            wdata_q    <= '0;
            last_q     <= REQ_B;
            owner_q    <= REQ_A;
            o_a_rvalid <= 1'b0;
            o_b_rvalid <= 1'b0;
            o_a_rdata  <= '0;
            o_b_rdata  <= '0;
        end else begin
            state_q    <= state_nxt;
            o_ram_ce   <= ce_nxt;
            o_ram_rw   <= rw_nxt;
            o_ram_addr <= addr_nxt;
            wdata_q    <= wdata_nxt;
            last_q     <= last_nxt;
            owner_q    <= owner_nxt;
            o_a_rvalid <= a_rvalid_nxt;
            o_b_rvalid <= b_rvalid_nxt;
            o_a_rdata  <= a_rdata_nxt;
            o_b_rdata  <= b_rdata_nxt;
        end
    end

endmodule
